// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module      : load_store_unit_if
// Description : Core request/response and byte-wide data memory signals of
//               the load/store unit, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] endereco;
    logic [31:0] write_data;
    logic [31:0] read_data;

    // master: the load/store unit itself
    modport master (
        input  req, we, funct3, addr, wdata, read_data,
        output ready, done, err, rdata, mem_read, mem_write, endereco, write_data
    );

    // slave: the core plus data memory environment
    modport slave (
        output req, we, funct3, addr, wdata, read_data,
        input  ready, done, err, rdata, mem_read, mem_write, endereco, write_data
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store initiator splitting each access into
//               big-endian single-byte memory cycles, with extension/errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit (
    input  wire logic         clk,
    input  wire logic         rst_n,
    load_store_unit_if.master bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    logic        r_we;
    logic        r_err;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [23:0] r_acc;
    logic [31:0] r_rdata;
    logic [1:0]  r_cnt;
    logic [1:0]  r_last;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misal;
    logic        w_bad;
    logic [1:0]  w_last_in;
    logic [31:0] w_wdata_al;
    logic        w_last_cyc;
    logic [31:0] w_acc_next;
    logic [31:0] w_ext;
    logic        w_unused;

    assign w_accept   = (r_state == S_IDLE) && bus.req;
    assign w_last_cyc = (r_state == S_ACCESS) && (r_cnt == r_last);
    assign w_acc_next = {r_acc, bus.read_data[7:0]};
    assign w_unused   = ^bus.read_data[31:8];

    // Request decode: byte count, msb-first store alignment, error check
    always_comb begin
        w_last_in  = 2'd3;
        w_wdata_al = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                w_last_in  = 2'd0;
                w_wdata_al = {bus.wdata[7:0], 24'h000000};
            end
            2'b01: begin
                w_last_in  = 2'd1;
                w_wdata_al = {bus.wdata[15:0], 16'h0000};
            end
            default: begin
                w_last_in  = 2'd3;
                w_wdata_al = bus.wdata;
            end
        endcase
        if (bus.we)
            w_illegal = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
        else
            w_illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
        w_misal = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                  ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
        w_bad   = w_illegal || w_misal;
    end

    always_comb begin
        w_ext = w_acc_next;
        case (r_f3)
            3'b000:  w_ext = {{24{w_acc_next[7]}},  w_acc_next[7:0]};
            3'b001:  w_ext = {{16{w_acc_next[15]}}, w_acc_next[15:0]};
            3'b100:  w_ext = {24'h000000, w_acc_next[7:0]};
            3'b101:  w_ext = {16'h0000,   w_acc_next[15:0]};
            default: w_ext = w_acc_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.req) w_next = w_bad ? S_DONE : S_ACCESS;
            S_ACCESS: if (r_cnt == r_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Load bytes shift in at the bottom; the first byte ends up most significant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_acc   <= 24'h0;
            r_rdata <= 32'h0;
            r_cnt   <= 2'd0;
            r_last  <= 2'd0;
        end else if (w_accept) begin
            r_we    <= bus.we;
            r_f3    <= bus.funct3;
            r_addr  <= bus.addr;
            r_wdata <= w_wdata_al;
            r_last  <= w_last_in;
            r_cnt   <= 2'd0;
            r_acc   <= 24'h0;
            r_err   <= w_bad;
            if (w_bad)
                r_rdata <= 32'h0;
        end else if (r_state == S_ACCESS) begin
            r_cnt   <= r_cnt + 2'd1;
            r_wdata <= {r_wdata[23:0], 8'h00};
            r_acc   <= w_acc_next[23:0];
            if (w_last_cyc)
                r_rdata <= r_we ? 32'h0 : w_ext;
        end
    end

    always_comb begin
        bus.ready      = 1'b0;
        bus.done       = 1'b0;
        bus.err        = 1'b0;
        bus.rdata      = r_rdata;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.endereco   = 32'h0;
        bus.write_data = 32'h0;
        case (r_state)
            S_IDLE: bus.ready = 1'b1;
            S_ACCESS: begin
                bus.mem_read   = !r_we;
                bus.mem_write  = r_we;
                bus.endereco   = r_addr + {30'h0, r_cnt};
                bus.write_data = r_we ? {24'h000000, r_wdata[31:24]} : 32'h0;
            end
            S_DONE: begin
                bus.done = 1'b1;
                bus.err  = r_err;
            end
            default: bus.ready = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Randomised self-checking bench for load_store_unit against a
//               transaction-level model with a byte memory image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    typedef struct packed {
        logic        ready;
        logic        done;
        logic        err;
        logic [31:0] rdata;
        logic        mr;
        logic        mw;
        logic [31:0] ea;
        logic [31:0] wd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Data memory environment: combinational read, write on the clock edge
    logic [7:0]  mem [0:255];
    logic        mem_inited = 1'b0;
    logic [23:0] junk = 24'h0;

    function automatic logic [7:0] init_byte(input int i);
        if (i < 3)       return 8'h00;
        else if (i == 3) return 8'h09;
        else             return 8'((i * 37 + 5) & 255);
    endfunction

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            mem_inited <= 1'b1;
        end else if (bus.mem_write) begin
            mem[bus.endereco[7:0]] <= bus.write_data[7:0];
        end
    end

    always @(negedge clk) junk <= 24'($urandom);

    assign bus.read_data = {junk, mem[bus.endereco[7:0]]};

    // Reference model state
    logic [7:0]  ref_mem [0:255];
    logic [31:0] m_rdata = 32'h0;
    vec_t        exp_q [$];

    function automatic vec_t mkvec(input logic r, input logic d, input logic e,
                                   input logic [31:0] rd, input logic mr,
                                   input logic mw, input logic [31:0] ea,
                                   input logic [31:0] wd);
        vec_t v;
        v.ready = r; v.done = d; v.err = e; v.rdata = rd;
        v.mr = mr; v.mw = mw; v.ea = ea; v.wd = wd;
        return v;
    endfunction

    function automatic vec_t cur();
        return mkvec(bus.ready, bus.done, bus.err, bus.rdata, bus.mem_read,
                     bus.mem_write, bus.endereco, bus.write_data);
    endfunction

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b done=%b err=%b rdata=%h rd=%b wr=%b ea=%h wd=%h, required rdy=%b done=%b err=%b rdata=%h rd=%b wr=%b ea=%h wd=%h",
                     name, act.ready, act.done, act.err, act.rdata, act.mr, act.mw, act.ea, act.wd,
                     exp.ready, exp.done, exp.err, exp.rdata, exp.mr, exp.mw, exp.ea, exp.wd);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) chk("cycle", cur(), exp_q.pop_front());
    end

    // Issue one request at the next ready cycle; cut>=0 predicts only that many
    // access cycles (the request is then aborted by reset).
    task automatic issue(input logic iwe, input logic [2:0] if3,
                         input logic [31:0] iaddr, input logic [31:0] iwd,
                         input int cut);
        int n;
        int waited;
        logic bad;
        logic [31:0] val;
        logic [31:0] a;
        waited = 0;
        @(negedge clk);
        while (!bus.ready && waited < 20) begin
            bus.req    = 1'($urandom_range(0, 1));
            bus.we     = 1'($urandom_range(0, 1));
            bus.funct3 = 3'($urandom);
            bus.addr   = $urandom;
            bus.wdata  = $urandom;
            @(negedge clk);
            waited++;
        end
        if (!bus.ready) begin
            n_checks++;
            n_err++;
            $display("FAIL ready_timeout: got ready=0 required ready=1 within 20 cycles");
        end
        bus.req = 1'b1; bus.we = iwe; bus.funct3 = if3; bus.addr = iaddr; bus.wdata = iwd;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.we = ~iwe; bus.funct3 = 3'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;

        case (if3)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            default:        n = 4;
        endcase
        if (iwe) bad = !(if3 == 3'b000 || if3 == 3'b001 || if3 == 3'b010);
        else     bad = (if3 == 3'b011 || if3 == 3'b110 || if3 == 3'b111);
        if (!bad && n == 2 && iaddr[0]) bad = 1'b1;
        if (!bad && n == 4 && iaddr[1:0] != 2'b00) bad = 1'b1;

        if (bad) begin
            m_rdata = 32'h0;
            exp_q.push_back(mkvec(0, 1, 1, m_rdata, 0, 0, 0, 0));
            exp_q.push_back(mkvec(1, 0, 0, m_rdata, 0, 0, 0, 0));
            return;
        end
        val = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (cut >= 0 && i >= cut) return;
            a = iaddr + 32'(i);
            if (iwe) begin
                exp_q.push_back(mkvec(0, 0, 0, m_rdata, 0, 1, a,
                                      {24'h0, 8'((iwd >> (8 * (n - 1 - i))) & 32'hFF)}));
                ref_mem[a[7:0]] = 8'((iwd >> (8 * (n - 1 - i))) & 32'hFF);
            end else begin
                exp_q.push_back(mkvec(0, 0, 0, m_rdata, 1, 0, a, 0));
                val = val * 256 + {24'h0, ref_mem[a[7:0]]};
            end
        end
        if (cut >= 0) return;
        if (iwe) m_rdata = 32'h0;
        else begin
            case (if3)
                3'b000:  m_rdata = (val >= 32'h80)   ? val + 32'hFFFFFF00 : val;
                3'b001:  m_rdata = (val >= 32'h8000) ? val + 32'hFFFF0000 : val;
                default: m_rdata = val;
            endcase
        end
        exp_q.push_back(mkvec(0, 1, 0, m_rdata, 0, 0, 0, 0));
        exp_q.push_back(mkvec(1, 0, 0, m_rdata, 0, 0, 0, 0));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int bad_bytes;
        logic [2:0]  f3;
        logic [31:0] a;
        logic        w;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010;
        bus.addr = 32'h0; bus.wdata = 32'h0;

        // Reset with req held high: no strobes, idle outputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", cur(), mkvec(1, 0, 0, 0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("post_reset", cur(), mkvec(1, 0, 0, 0, 0, 0, 0, 0));

        issue(0, 3'b010, 32'h0, 32'h0, -1);
        drain();
        chk32("lw0_rdata", bus.rdata, 32'h00000009);

        issue(1, 3'b001, 32'h10, 32'h1234ABCD, -1);
        drain();
        chk32("sh_mem10", {24'h0, mem[8'h10]}, 32'h000000AB);
        chk32("sh_mem11", {24'h0, mem[8'h11]}, 32'h000000CD);
        issue(0, 3'b001, 32'h10, 32'h0, -1);
        drain();
        chk32("lh_rdata", bus.rdata, 32'hFFFFABCD);
        issue(0, 3'b101, 32'h10, 32'h0, -1);
        drain();
        chk32("lhu_rdata", bus.rdata, 32'h0000ABCD);

        issue(1, 3'b000, 32'h21, 32'h00000080, -1);
        issue(0, 3'b000, 32'h21, 32'h0, -1);
        drain();
        chk32("lb_rdata", bus.rdata, 32'hFFFFFF80);
        issue(0, 3'b100, 32'h21, 32'h0, -1);
        drain();
        chk32("lbu_rdata", bus.rdata, 32'h00000080);

        issue(0, 3'b010, 32'h6, 32'h0, -1);
        drain();
        chk32("err_lw_mis_rdata", bus.rdata, 32'h0);
        issue(0, 3'b100, 32'h3, 32'h0, -1);
        issue(1, 3'b001, 32'h13, 32'h5555AAAA, -1);
        drain();
        chk32("err_sh_mis_mem13", {24'h0, mem[8'h13]}, {24'h0, ref_mem[8'h13]});
        issue(0, 3'b011, 32'h0, 32'h0, -1);
        issue(1, 3'b100, 32'h0, 32'h0, -1);
        drain();

        // Store word aborted by reset after two byte commits
        issue(1, 3'b010, 32'h40, 32'hDEADBEEF, 2);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_rdata = 32'h0;
        @(negedge clk);
        chk("mid_reset", cur(), mkvec(1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_abort", cur(), mkvec(1, 0, 0, 0, 0, 0, 0, 0));
        end
        chk32("abort_mem40", {24'h0, mem[8'h40]}, 32'h000000DE);
        chk32("abort_mem41", {24'h0, mem[8'h41]}, 32'h000000AD);
        chk32("abort_mem42", {24'h0, mem[8'h42]}, {24'h0, init_byte(8'h42)});
        chk32("abort_mem43", {24'h0, mem[8'h43]}, {24'h0, init_byte(8'h43)});
        issue(0, 3'b010, 32'h40, 32'h0, -1);
        drain();

        // Random back-to-back traffic
        for (int t = 0; t < 300; t++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            issue(w, f3, a, $urandom, -1);
        end
        drain();

        bad_bytes = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
        chk32("mem_image", 32'(bad_bytes), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish before 200us");
        $fatal(1);
    end

endmodule

`default_nettype wire
